k054539_ram_arbiter: RTL and testbench
======================================

// Module: k054539_ram_arbiter
// PURPOSE
//  Time-slot arbiter for the 054539 internal sample/register RAM (two 8-bit banks A/B, 7-bit word address).
//  Shares the RAM between host CPU byte accesses and the internal voice engine on a fixed 2^SLOT_BITS-slot frame.
//  Generates CPU wait, the per-bank write strobes, the RAM address/data mux and the read-capture strobe.
//  Sits between the host bus decode (CS/RD/WR/AB) and the RAM macro, aligned to the clock divider via SLOT_SYNC.
// PARAMETERS
//  SLOT_BITS      4         frame = 2^SLOT_BITS slots, one slot per CLK
//  CPU_SLOT_MASK  16'hAAAA  bit s=1: slot s owned by CPU, 0: owned by engine (width 2^SLOT_BITS)
// PORTS
//  CLK          in   1   system clock, all state on rising edge
//  RES          in   1   reset, asynchronous, active-high
//  SLOT_SYNC    in   1   frame-align pulse from clock divider; next slot counter value forced to 0
//  CPU_CS       in   1   RAM window selected (active-high, decoded upstream)
//  CPU_RD       in   1   host read strobe (active-high)
//  CPU_WR       in   1   host write strobe (active-high)
//  CPU_A        in   8   host byte address; [7:1] word, [0] bank select (1=A, 0=B)
//  CPU_DI       in   8   host write data
//  CPU_WAIT     out  1   host wait request
//  CPU_RD_STB   out  1   1-cycle pulse: RAM read data valid for host latch
//  ENG_REQ      in   1   engine access request for the current slot
//  ENG_A        in   7   engine word address
//  ENG_WE       in   2   engine write enables {A,B}
//  ENG_DI       in   16  engine write data {A[7:0],B[7:0]}
//  ENG_ACK      out  1   engine access performed this cycle
//  SLOT         out  SLOT_BITS  slot currently presented on RAM bus
//  RAM_SRC      out  1   0=engine owns bus, 1=CPU owns bus
//  RAM_ADDR     out  7   RAM word address
//  RAM_WE_A     out  1   bank A write enable (one CLK wide)
//  RAM_WE_B     out  1   bank B write enable
//  RAM_DIN_A    out  8   bank A write data
//  RAM_DIN_B    out  8   bank B write data
// BEHAVIOUR
//  - Reset: counter 0, state IDLE, SLOT=0, RAM_SRC=0, RAM_ADDR=0, WE_A/B=0, DIN=0, ENG_ACK=0, CPU_RD_STB=0, CPU_WAIT=0.
//  - CPU_WAIT forced 0 while RES high regardless of host inputs.
//  - Slot counter cnt increments every CLK, wraps 2^SLOT_BITS-1 -> 0. SLOT_SYNC=1: next cnt=0 (wins over wrap).
//  - All RAM_* outputs and ENG_ACK registered: decision made while cnt=s is presented next cycle with SLOT=s.
//  - Engine slot (mask bit 0): ENG_REQ=1 -> RAM_SRC=0, RAM_ADDR=ENG_A, WE={ENG_WE}, DIN=ENG_DI, ENG_ACK=1.
//    ENG_REQ=0 -> RAM_SRC=0, WE=0, ENG_ACK=0. Engine never uses CPU slots.
//  - CPU slot (mask bit 1): served only if state=PEND; else RAM_SRC=1, WE=0 (idle slot, not lent to engine).
//  - CPU FSM, req = CPU_CS & (CPU_RD|CPU_WR):
//    IDLE   : req -> PEND (latch A, DI, op; WR wins if RD and WR both set).
//    PEND   : CS=0 -> IDLE (abort, no RAM access); CPU slot -> ACCESS.
//    ACCESS : RAM_SRC=1, RAM_ADDR=A[7:1]; write: WE_A=A[0], WE_B=~A[0], DIN_A=DIN_B=DI. -> DONE.
//    DONE   : read -> CPU_RD_STB=1 this cycle. -> HOLD.
//    HOLD   : ~req -> IDLE. Held strobe never retriggers (one RAM access per host cycle).
//  - CPU_WAIT = (IDLE & req) | PEND | ACCESS; combinational so wait asserts in the request cycle.
//  - Worst-case wait = distance to next CPU slot + 2 cycles.
//  - Reset mid-access: state IDLE, pending access discarded, no WE issued.
// STRUCTURE
//  - Package k054539_pkg: SLOT_BITS default, CPU_SLOT_MASK default, cpu_state_t {IDLE,PEND,ACCESS,DONE,HOLD}.
//  - Sub-module k054539_slot_counter: wrap counter with SLOT_SYNC, outputs cnt and cpu_slot = CPU_SLOT_MASK[cnt].
//  - Top: CPU FSM, RAM output mux/registers.
// TESTING (defaults: 16 slots, odd slots CPU)
//  1. RES=1 with CPU_CS=1,CPU_WR=1 -> CPU_WAIT=0, WE_A/B=0, SLOT=0, RAM_SRC=0; release -> SLOT counts 0,1,2..15,0.
//  2. Write A=0x15 DI=0x5A raised at cnt=2 -> bus at SLOT=3: RAM_SRC=1, RAM_ADDR=0x0A, WE_A=1, WE_B=0, DIN_A=0x5A; WAIT high 3 cycles.
//  3. Read A=0x20 raised at cnt=3 -> served SLOT=5, WE_A=WE_B=0, RAM_ADDR=0x10, CPU_RD_STB 1 cycle later, WAIT low with it.
//  4. WR held 40 cycles after completion -> exactly one WE pulse; drop and re-raise -> second pulse.
//  5. ENG_REQ=1, ENG_A=0x33, ENG_WE=2'b01 at cnt=4 with CPU pending -> SLOT=4 engine WE_B=1, ENG_ACK=1; CPU served SLOT=5.
//  6. SLOT_SYNC at cnt=9 -> next SLOT sequence 9,0,1; RES pulse while PEND -> WAIT 0 asynchronously, no WE follows.

Source files
------------

// File: rtl/k054539_pkg.sv
// k054539 RAM arbiter shared definitions.
// Default frame geometry, CPU FSM states and a bank write-enable helper.
package k054539_pkg;

  localparam int          K_SLOT_BITS     = 4;
  localparam logic [15:0] K_CPU_SLOT_MASK = 16'hAAAA;

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    ACCESS,
    DONE,
    HOLD
  } cpu_state_t;

  // Host byte lane decode: A[0]=1 selects bank A, 0 selects bank B.
  // Result is {we_a, we_b}.
  function automatic logic [1:0] cpu_bank_we(
    input logic wr,
    input logic bank_a
  );
    return {wr & bank_a, wr & ~bank_a};
  endfunction

endpackage

// File: rtl/k054539_slot_counter.sv
// k054539 RAM frame slot counter.
// Ports: CLK, RES (async high), SLOT_SYNC (frame align) -> cnt, cpu_slot.
module k054539_slot_counter
  import k054539_pkg::*;
#(
  parameter int SLOT_BITS = K_SLOT_BITS,
  parameter logic [(1<<SLOT_BITS)-1:0] CPU_SLOT_MASK =
    K_CPU_SLOT_MASK
) (
  input  logic                 CLK,
  input  logic                 RES,
  input  logic                 SLOT_SYNC,
  output logic [SLOT_BITS-1:0] cnt,
  output logic                 cpu_slot
);

  // Frame length is a power of two, so natural
  // overflow gives the wrap; sync beats the wrap.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      cnt <= '0;
    end else if (SLOT_SYNC) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + SLOT_BITS'(1);
    end
  end

  assign cpu_slot = CPU_SLOT_MASK[cnt];

endmodule

// File: rtl/k054539_ram_arbiter.sv
// k054539 sample/register RAM time-slot arbiter (host CPU vs voice engine).
// Ports: CLK, RES, SLOT_SYNC; host CPU_CS/RD/WR/A/DI -> CPU_WAIT, CPU_RD_STB;
// engine ENG_REQ/A/WE/DI -> ENG_ACK; RAM bus SLOT, RAM_SRC, RAM_ADDR,
// RAM_WE_A/B, RAM_DIN_A/B (all registered, SLOT tags the presented slot).
module k054539_ram_arbiter
  import k054539_pkg::*;
#(
  parameter int SLOT_BITS = K_SLOT_BITS,
  parameter logic [(1<<SLOT_BITS)-1:0] CPU_SLOT_MASK =
    K_CPU_SLOT_MASK
) (
  input  logic                 CLK,
  input  logic                 RES,
  input  logic                 SLOT_SYNC,
  input  logic                 CPU_CS,
  input  logic                 CPU_RD,
  input  logic                 CPU_WR,
  input  logic [7:0]           CPU_A,
  input  logic [7:0]           CPU_DI,
  output logic                 CPU_WAIT,
  output logic                 CPU_RD_STB,
  input  logic                 ENG_REQ,
  input  logic [6:0]           ENG_A,
  input  logic [1:0]           ENG_WE,
  input  logic [15:0]          ENG_DI,
  output logic                 ENG_ACK,
  output logic [SLOT_BITS-1:0] SLOT,
  output logic                 RAM_SRC,
  output logic [6:0]           RAM_ADDR,
  output logic                 RAM_WE_A,
  output logic                 RAM_WE_B,
  output logic [7:0]           RAM_DIN_A,
  output logic [7:0]           RAM_DIN_B
);

  logic [SLOT_BITS-1:0] cnt;
  logic                 cpu_slot;
  logic                 req;
  logic                 serve;
  cpu_state_t           state;
  logic [7:0]           a_q;
  logic [7:0]           di_q;
  logic                 wr_q;
  logic [1:0]           cpu_we;

  k054539_slot_counter #(
    .SLOT_BITS     (SLOT_BITS),
    .CPU_SLOT_MASK (CPU_SLOT_MASK)
  ) u_cnt (
    .CLK       (CLK),
    .RES       (RES),
    .SLOT_SYNC (SLOT_SYNC),
    .cnt       (cnt),
    .cpu_slot  (cpu_slot)
  );

  assign req    = CPU_CS & (CPU_RD | CPU_WR);
  assign cpu_we = cpu_bank_we(wr_q, a_q[0]);

  // A pending access is only taken while the host
  // still selects the window; a dropped CS aborts.
  assign serve = (state == PEND) & CPU_CS & cpu_slot;

  // Combinational so the host stalls in the very
  // cycle it raises the strobe.
  assign CPU_WAIT = ~RES & (
    ((state == IDLE) & req) |
    (state == PEND) |
    (state == ACCESS));

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state      <= IDLE;
      a_q        <= '0;
      di_q       <= '0;
      wr_q       <= 1'b0;
      SLOT       <= '0;
      RAM_SRC    <= 1'b0;
      RAM_ADDR   <= '0;
      RAM_WE_A   <= 1'b0;
      RAM_WE_B   <= 1'b0;
      RAM_DIN_A  <= '0;
      RAM_DIN_B  <= '0;
      ENG_ACK    <= 1'b0;
      CPU_RD_STB <= 1'b0;
    end else begin
      SLOT       <= cnt;
      RAM_WE_A   <= 1'b0;
      RAM_WE_B   <= 1'b0;
      ENG_ACK    <= 1'b0;
      CPU_RD_STB <= 1'b0;

      // Bus owner follows the slot mask; CPU slots
      // left unused are never lent to the engine.
      unique case (1'b1)
        !cpu_slot: begin
          RAM_SRC <= 1'b0;
          if (ENG_REQ) begin
            RAM_ADDR  <= ENG_A;
            RAM_WE_A  <= ENG_WE[1];
            RAM_WE_B  <= ENG_WE[0];
            RAM_DIN_A <= ENG_DI[15:8];
            RAM_DIN_B <= ENG_DI[7:0];
            ENG_ACK   <= 1'b1;
          end
        end
        cpu_slot: begin
          RAM_SRC <= 1'b1;
          if (serve) begin
            RAM_ADDR  <= a_q[7:1];
            RAM_WE_A  <= cpu_we[1];
            RAM_WE_B  <= cpu_we[0];
            RAM_DIN_A <= di_q;
            RAM_DIN_B <= di_q;
          end
        end
        default: begin
          RAM_SRC <= 1'b0;
        end
      endcase

      unique case (state)
        IDLE: begin
          if (req) begin
            state <= PEND;
            a_q   <= CPU_A;
            di_q  <= CPU_DI;
            wr_q  <= CPU_WR;
          end
        end
        PEND: begin
          if (!CPU_CS) begin
            state <= IDLE;
          end else if (cpu_slot) begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          state      <= DONE;
          CPU_RD_STB <= ~wr_q;
        end
        DONE: begin
          state <= HOLD;
        end
        HOLD: begin
          // Held strobe must drop before another
          // host cycle may start.
          if (!req) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_k054539_ram_arbiter.sv
// k054539 RAM arbiter bench.
// Directed frame scenarios plus random traffic against a transaction model.
module tb_k054539_ram_arbiter;

  localparam logic [15:0] MASK = 16'hAAAA;

  logic        CLK = 1'b0;
  logic        RES;
  logic        SLOT_SYNC;
  logic        CPU_CS;
  logic        CPU_RD;
  logic        CPU_WR;
  logic [7:0]  CPU_A;
  logic [7:0]  CPU_DI;
  logic        CPU_WAIT;
  logic        CPU_RD_STB;
  logic        ENG_REQ;
  logic [6:0]  ENG_A;
  logic [1:0]  ENG_WE;
  logic [15:0] ENG_DI;
  logic        ENG_ACK;
  logic [3:0]  SLOT;
  logic        RAM_SRC;
  logic [6:0]  RAM_ADDR;
  logic        RAM_WE_A;
  logic        RAM_WE_B;
  logic [7:0]  RAM_DIN_A;
  logic [7:0]  RAM_DIN_B;

  always #5 CLK = ~CLK;

  k054539_ram_arbiter dut (
    .CLK        (CLK),
    .RES        (RES),
    .SLOT_SYNC  (SLOT_SYNC),
    .CPU_CS     (CPU_CS),
    .CPU_RD     (CPU_RD),
    .CPU_WR     (CPU_WR),
    .CPU_A      (CPU_A),
    .CPU_DI     (CPU_DI),
    .CPU_WAIT   (CPU_WAIT),
    .CPU_RD_STB (CPU_RD_STB),
    .ENG_REQ    (ENG_REQ),
    .ENG_A      (ENG_A),
    .ENG_WE     (ENG_WE),
    .ENG_DI     (ENG_DI),
    .ENG_ACK    (ENG_ACK),
    .SLOT       (SLOT),
    .RAM_SRC    (RAM_SRC),
    .RAM_ADDR   (RAM_ADDR),
    .RAM_WE_A   (RAM_WE_A),
    .RAM_WE_B   (RAM_WE_B),
    .RAM_DIN_A  (RAM_DIN_A),
    .RAM_DIN_B  (RAM_DIN_B)
  );

  int n_chk;
  int n_fail;
  int cyc;
  int m_cnt;

  // host transaction: active, still owed a slot,
  // cycle it was served in, latched request
  bit         h_act;
  bit         h_owed;
  int         h_srv;
  bit         h_wr;
  logic [7:0] h_a;
  logic [7:0] h_di;

  // expected registered bus for the next cycle
  logic [3:0] e_slot;
  logic       e_src;
  logic [6:0] e_addr;
  bit         e_addr_v;
  logic       e_we_a;
  logic       e_we_b;
  logic [7:0] e_din_a;
  logic [7:0] e_din_b;
  logic       e_ack;

  int wait_cnt;
  int stb_cnt;
  int cpu_we_cnt;
  int last_we_slot;
  int last_we_addr;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt    = 0;
    h_act    = 0;
    h_owed   = 0;
    h_srv    = -1;
    e_slot   = 0;
    e_src    = 0;
    e_addr   = 0;
    e_addr_v = 1;
    e_we_a   = 0;
    e_we_b   = 0;
    e_ack    = 0;
  endtask

  task automatic idle_in();
    SLOT_SYNC = 0;
    CPU_CS    = 0;
    CPU_RD    = 0;
    CPU_WR    = 0;
    ENG_REQ   = 0;
  endtask

  // One clock: inputs already driven by caller.
  task automatic tick();
    bit req;
    bit start;
    bit abort;
    bit serve;
    bit x_wait;
    bit x_stb;
    #1;
    req    = CPU_CS && (CPU_RD || CPU_WR);
    start  = !h_act && req;
    abort  = h_owed && !CPU_CS;
    serve  = h_owed && CPU_CS && MASK[m_cnt];
    x_wait = start || h_owed ||
             (h_srv >= 0 && cyc == h_srv + 1);
    x_stb  = (h_srv >= 0) && (cyc == h_srv + 2) && !h_wr;
    check("cpu_wait", CPU_WAIT, x_wait);
    check("rd_stb", CPU_RD_STB, x_stb);
    if (CPU_WAIT) wait_cnt++;
    if (CPU_RD_STB) stb_cnt++;

    e_slot   = m_cnt[3:0];
    e_we_a   = 0;
    e_we_b   = 0;
    e_ack    = 0;
    e_addr_v = 0;
    if (!MASK[m_cnt]) begin
      e_src = 0;
      if (ENG_REQ) begin
        e_addr   = ENG_A;
        e_addr_v = 1;
        e_we_a   = ENG_WE[1];
        e_we_b   = ENG_WE[0];
        e_din_a  = ENG_DI[15:8];
        e_din_b  = ENG_DI[7:0];
        e_ack    = 1;
      end
    end else begin
      e_src = 1;
      if (serve) begin
        e_addr   = h_a[7:1];
        e_addr_v = 1;
        if (h_wr) begin
          if (h_a[0]) e_we_a = 1;
          else        e_we_b = 1;
          e_din_a = h_di;
          e_din_b = h_di;
        end
      end
    end

    if (start) begin
      h_act  = 1;
      h_owed = 1;
      h_srv  = -1;
      h_wr   = CPU_WR;
      h_a    = CPU_A;
      h_di   = CPU_DI;
    end else if (abort) begin
      h_act  = 0;
      h_owed = 0;
    end else if (serve) begin
      h_owed = 0;
      h_srv  = cyc;
    end else if (h_act && !h_owed &&
                 cyc >= h_srv + 3 && !req) begin
      h_act = 0;
    end
    m_cnt = SLOT_SYNC ? 0 : (m_cnt + 1) % 16;

    @(posedge CLK);
    #1;
    check("slot", SLOT, e_slot);
    check("src", RAM_SRC, e_src);
    check("we_a", RAM_WE_A, e_we_a);
    check("we_b", RAM_WE_B, e_we_b);
    check("eng_ack", ENG_ACK, e_ack);
    if (e_addr_v) check("addr", RAM_ADDR, e_addr);
    if (e_we_a) check("din_a", RAM_DIN_A, e_din_a);
    if (e_we_b) check("din_b", RAM_DIN_B, e_din_b);
    if (RAM_SRC && (RAM_WE_A || RAM_WE_B)) begin
      cpu_we_cnt++;
      last_we_slot = SLOT;
      last_we_addr = RAM_ADDR;
    end
    cyc++;
  endtask

  task automatic align(input int c);
    int g;
    g = 0;
    while (m_cnt != c && g < 40) begin
      tick();
      g++;
    end
    check("align", m_cnt, c);
  endtask

  // Async reset in mid-cycle with the host strobes
  // left as they are, then a clean release.
  task automatic do_reset();
    #2;
    RES = 1;
    #1;
    check("rst_wait", CPU_WAIT, 0);
    check("rst_we_a", RAM_WE_A, 0);
    check("rst_we_b", RAM_WE_B, 0);
    check("rst_slot", SLOT, 0);
    check("rst_src", RAM_SRC, 0);
    check("rst_ack", ENG_ACK, 0);
    check("rst_stb", CPU_RD_STB, 0);
    repeat (2) @(posedge CLK);
    #1;
    check("rst_hold_wait", CPU_WAIT, 0);
    idle_in();
    RES = 0;
    model_reset();
  endtask

  initial begin
    int hl;
    int gap;
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    wait_cnt = 0;
    stb_cnt = 0;
    cpu_we_cnt = 0;
    CPU_A = 0;
    CPU_DI = 0;
    ENG_A = 0;
    ENG_WE = 0;
    ENG_DI = 0;
    idle_in();
    RES = 1;
    CPU_CS = 1;
    CPU_WR = 1;
    @(posedge CLK);
    #1;
    do_reset();

    // frame count from reset
    for (int k = 0; k < 17; k++) begin
      tick();
      check("t1_slot", SLOT, k % 16);
    end

    // write raised at slot 2, served at slot 3
    align(2);
    wait_cnt = 0;
    cpu_we_cnt = 0;
    CPU_CS = 1;
    CPU_WR = 1;
    CPU_A = 8'h15;
    CPU_DI = 8'h5A;
    repeat (6) tick();
    check("t2_wait", wait_cnt, 3);
    check("t2_we_cnt", cpu_we_cnt, 1);
    check("t2_we_slot", last_we_slot, 3);
    check("t2_we_addr", last_we_addr, 8'h0A);

    // held strobe must not retrigger
    repeat (40) tick();
    check("t4_held", cpu_we_cnt, 1);
    idle_in();
    repeat (2) tick();
    CPU_CS = 1;
    CPU_WR = 1;
    repeat (20) tick();
    check("t4_again", cpu_we_cnt, 2);
    idle_in();
    repeat (2) tick();

    // read raised at slot 3, served at slot 5
    align(3);
    wait_cnt = 0;
    stb_cnt = 0;
    CPU_CS = 1;
    CPU_RD = 1;
    CPU_A = 8'h20;
    repeat (8) tick();
    check("t3_wait", wait_cnt, 4);
    check("t3_stb", stb_cnt, 1);
    idle_in();
    repeat (2) tick();

    // engine slot kept while CPU is pending
    align(3);
    CPU_CS = 1;
    CPU_WR = 1;
    CPU_A = 8'h41;
    CPU_DI = 8'hC3;
    tick();
    ENG_REQ = 1;
    ENG_A = 7'h33;
    ENG_WE = 2'b01;
    ENG_DI = 16'h1234;
    tick();
    check("t5_eslot", SLOT, 4);
    check("t5_ewe_b", RAM_WE_B, 1);
    check("t5_eack", ENG_ACK, 1);
    ENG_REQ = 0;
    tick();
    check("t5_cslot", SLOT, 5);
    check("t5_cwe_a", RAM_WE_A, 1);
    check("t5_caddr", RAM_ADDR, 7'h20);
    idle_in();
    repeat (4) tick();

    // frame sync
    align(9);
    SLOT_SYNC = 1;
    tick();
    check("t6_s9", SLOT, 9);
    SLOT_SYNC = 0;
    tick();
    check("t6_s0", SLOT, 0);
    tick();
    check("t6_s1", SLOT, 1);

    // reset while pending discards the access
    align(1);
    cpu_we_cnt = 0;
    CPU_CS = 1;
    CPU_WR = 1;
    CPU_A = 8'h7F;
    CPU_DI = 8'hEE;
    tick();
    check("t6_pend_wait", CPU_WAIT, 1);
    do_reset();
    repeat (20) tick();
    check("t6_no_we", cpu_we_cnt, 0);

    // random traffic
    hl = 0;
    gap = 0;
    for (int i = 0; i < 3000; i++) begin
      SLOT_SYNC = ($urandom_range(0, 31) == 0);
      ENG_REQ = $urandom_range(0, 1);
      ENG_A = 7'($urandom);
      ENG_WE = 2'($urandom);
      ENG_DI = 16'($urandom);
      if (hl > 0) begin
        hl--;
        CPU_A = 8'($urandom);
        CPU_DI = 8'($urandom);
        if ($urandom_range(0, 15) == 0) CPU_CS = 0;
      end else if (gap > 0) begin
        gap--;
        CPU_CS = 0;
        CPU_RD = 0;
        CPU_WR = 0;
      end else begin
        hl = $urandom_range(1, 30);
        gap = $urandom_range(0, 4);
        CPU_CS = 1;
        {CPU_RD, CPU_WR} = 2'($urandom_range(1, 3));
        CPU_A = 8'($urandom);
        CPU_DI = 8'($urandom);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
